// File: rtl/serializer_pkg.sv
// Shared encodings for the serializer and the downstream FSM stage.
package serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

endpackage

// File: rtl/ser_bit_counter.sv
// Modulo-N bit counter with synchronous clear, enable and a terminal-count flag.
module ser_bit_counter
  import serializer_pkg::*;
#(
  parameter int unsigned N  = DEFAULT_WIDTH,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(N - 1));

  // Count 0..N-1 and wrap; clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word per valid/ready handshake,
// emitted one bit per clock with sout_valid and an end-of-frame done pulse.
// Optional feature: define SERIALIZER_PARITY_EN to append an even-parity bit.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter logic        MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             cnt_en;
  logic             last_bit;
  logic             accept;
`ifdef SERIALIZER_PARITY_EN
  logic             par;
`endif

  // cnt is the index of the bit currently on sout; cleared on every accept.
  ser_bit_counter #(
    .N  (WIDTH),
    .CW (CW)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (tc)
  );

  // Handshake and status decode from state/counter only.
  always_comb begin
    cnt_en = (state == ST_SHIFT);
`ifdef SERIALIZER_PARITY_EN
    last_bit = (state == ST_PAR);
`else
    last_bit = (state == ST_SHIFT) && tc;
`endif
    load_ready = (state == ST_IDLE) || last_bit;
    accept     = load_valid && load_ready;
    busy       = (state != ST_IDLE);
  end

  // Frame FSM with registered serial outputs; sout is loaded with the first
  // bit on the accept edge and sr holds the bits still to go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sr         <= '0;
      sout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      done       <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par        <= 1'b0;
`endif
    end else if (accept) begin
      state      <= ST_SHIFT;
      sout       <= MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
      sr         <= MSB_FIRST ? (load_data << 1) : (load_data >> 1);
      sout_valid <= 1'b1;
      done       <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par        <= ^load_data;
`endif
    end else begin
      case (state)
        ST_SHIFT: begin
          if (tc) begin
`ifdef SERIALIZER_PARITY_EN
            state      <= ST_PAR;
            sout       <= par;
            sout_valid <= 1'b1;
            done       <= 1'b1;
`else
            state      <= ST_IDLE;
            sout       <= IDLE_LEVEL;
            sout_valid <= 1'b0;
            done       <= 1'b0;
`endif
          end else begin
            sout       <= MSB_FIRST ? sr[WIDTH-1] : sr[0];
            sr         <= MSB_FIRST ? (sr << 1) : (sr >> 1);
            sout_valid <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
            done       <= 1'b0;
`else
            done       <= (cnt == CW'(WIDTH - 2));
`endif
          end
        end
        default: begin
          state      <= ST_IDLE;
          sout       <= IDLE_LEVEL;
          sout_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a queue-of-frame-bits reference model.
module tb_bit_serializer;

  localparam int unsigned W = 6;
`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } item_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lv  = 1'b0;
  logic [W-1:0] ld  = '0;

  logic sm, svm, dm, bm, rm;
  logic sl, svl, dl, bl, rl;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rm), .load_data(ld),
    .sout(sm), .sout_valid(svm), .done(dm), .busy(bm)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rl), .load_data(ld),
    .sout(sl), .sout_valid(svl), .done(dl), .busy(bl)
  );

  always #5 clk = ~clk;

  item_t      qm[$];
  item_t      ql[$];
  int         total = 0;
  int         bad   = 0;
  bit         acc;
  logic [4:0] expm, expl;

  // Expected {sout, sout_valid, done, busy, load_ready} from the bits pending on the line.
  function automatic logic [4:0] exp_of(input bit empty, input item_t h);
    if (empty) return 5'b00001;
    return {h.b, 1'b1, h.last, 1'b1, h.last};
  endfunction

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = int'(W) - 1; i >= 0; i--) qm.push_back(item_t'{b: d[i], last: (i == 0) && !PAR});
    for (int i = 0; i < int'(W); i++) ql.push_back(item_t'{b: d[i], last: (i == int'(W) - 1) && !PAR});
    if (PAR) begin
      qm.push_back(item_t'{b: ^d, last: 1'b1});
      ql.push_back(item_t'{b: ^d, last: 1'b1});
    end
  endtask

  // Advance one clock, update the model, land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    acc = lv && (qm.size() == 0 || qm[0].last);
    if (qm.size() != 0) void'(qm.pop_front());
    if (ql.size() != 0) void'(ql.pop_front());
    if (acc) push_frame(ld);
    expm = exp_of(qm.size() == 0, (qm.size() != 0) ? qm[0] : item_t'(2'b00));
    expl = exp_of(ql.size() == 0, (ql.size() != 0) ? ql[0] : item_t'(2'b00));
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({sm, svm, dm, bm, rm} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_msb got=%b want=00001", {sm, svm, dm, bm, rm});
    end
    total++;
    if ({sl, svl, dl, bl, rl} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_lsb got=%b want=00001", {sl, svl, dl, bl, rl});
    end
    #12 rst = 1'b0;
    qm.delete();
    ql.delete();
    step();
  endtask

  task automatic test_single();
    logic [5:0] pat;
    pat = 6'b101100;
    lv = 1'b1;
    ld = pat;
    step();
    lv = 1'b0;
    ld = $urandom;
    for (int i = 0; i < int'(W) + int'(PAR) + 2; i++) begin
      total++;
      if ({sm, svm, dm, bm, rm} !== expm) begin
        bad++;
        $display("FAIL single_msb cyc=%0d got=%b want=%b", i, {sm, svm, dm, bm, rm}, expm);
      end
      total++;
      if ({sl, svl, dl, bl, rl} !== expl) begin
        bad++;
        $display("FAIL single_lsb cyc=%0d got=%b want=%b", i, {sl, svl, dl, bl, rl}, expl);
      end
      if (i < int'(W)) begin
        total++;
        if (sm !== pat[5 - i] || sl !== pat[i] || dm !== (i == int'(W) - 1 && !PAR)) begin
          bad++;
          $display("FAIL single_pattern cyc=%0d got msb=%b lsb=%b done=%b want msb=%b lsb=%b",
                   i, sm, sl, dm, pat[5 - i], pat[i]);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    int k;
    words[0] = 6'b101100;
    words[1] = 6'b010011;
    words[2] = W'($urandom);
    k = 0;
    lv = 1'b1;
    ld = words[0];
    for (int i = 0; i < 3 * (int'(W) + int'(PAR)) + 3; i++) begin
      step();
      if (acc) k++;
      lv = (k < 3);
      ld = (k < 3) ? words[k] : '0;
      total++;
      if ({sm, svm, dm, bm, rm} !== expm) begin
        bad++;
        $display("FAIL b2b_msb cyc=%0d got=%b want=%b", i, {sm, svm, dm, bm, rm}, expm);
      end
      total++;
      if ({sl, svl, dl, bl, rl} !== expl) begin
        bad++;
        $display("FAIL b2b_lsb cyc=%0d got=%b want=%b", i, {sl, svl, dl, bl, rl}, expl);
      end
    end
    total++;
    if (k != 3) begin
      bad++;
      $display("FAIL b2b_accepts got=%0d want=3", k);
    end
  endtask

  task automatic test_ignore_busy();
    lv = 1'b1;
    ld = W'($urandom);
    step();
    for (int i = 0; i < int'(W) + int'(PAR) + 2; i++) begin
      // pulse valid only while the model says the line is busy and not on its final bit
      lv = (qm.size() > 1) && ($urandom_range(0, 1) == 1);
      ld = W'($urandom);
      total++;
      if ({sm, svm, dm, bm, rm} !== expm) begin
        bad++;
        $display("FAIL ignore_msb cyc=%0d got=%b want=%b", i, {sm, svm, dm, bm, rm}, expm);
      end
      total++;
      if ({sl, svl, dl, bl, rl} !== expl) begin
        bad++;
        $display("FAIL ignore_lsb cyc=%0d got=%b want=%b", i, {sl, svl, dl, bl, rl}, expl);
      end
      step();
    end
    lv = 1'b0;
  endtask

  task automatic test_reset_mid();
    lv = 1'b1;
    ld = W'($urandom);
    step();
    lv = 1'b0;
    step();
    step();
    #3 rst = 1'b1;
    #1;
    total++;
    if ({sm, svm, dm, bm, rm} !== 5'b00001 || {sl, svl, dl, bl, rl} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_mid got msb=%b lsb=%b want=00001", {sm, svm, dm, bm, rm}, {sl, svl, dl, bl, rl});
    end
    qm.delete();
    ql.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    lv = 1'b1;
    ld = 6'b110100;
    step();
    lv = 1'b0;
    for (int i = 0; i < int'(W) + int'(PAR) + 2; i++) begin
      total++;
      if ({sm, svm, dm, bm, rm} !== expm) begin
        bad++;
        $display("FAIL post_reset_msb cyc=%0d got=%b want=%b", i, {sm, svm, dm, bm, rm}, expm);
      end
      total++;
      if ({sl, svl, dl, bl, rl} !== expl) begin
        bad++;
        $display("FAIL post_reset_lsb cyc=%0d got=%b want=%b", i, {sl, svl, dl, bl, rl}, expl);
      end
      step();
    end
  endtask

  task automatic test_zero_word();
    lv = 1'b1;
    ld = '0;
    step();
    lv = 1'b0;
    for (int i = 0; i < int'(W) + int'(PAR) + 1; i++) begin
      total++;
      if ({sm, svm, dm, bm, rm} !== expm) begin
        bad++;
        $display("FAIL zero_msb cyc=%0d got=%b want=%b", i, {sm, svm, dm, bm, rm}, expm);
      end
      total++;
      if (i < int'(W) + int'(PAR) && (sl !== 1'b0 || svl !== 1'b1)) begin
        bad++;
        $display("FAIL zero_lsb cyc=%0d got sout=%b valid=%b want sout=0 valid=1", i, sl, svl);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      lv = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      step();
      total++;
      if ({sm, svm, dm, bm, rm} !== expm) begin
        bad++;
        $display("FAIL random_msb cyc=%0d got=%b want=%b", i, {sm, svm, dm, bm, rm}, expm);
      end
      total++;
      if ({sl, svl, dl, bl, rl} !== expl) begin
        bad++;
        $display("FAIL random_lsb cyc=%0d got=%b want=%b", i, {sl, svl, dl, bl, rl}, expl);
      end
    end
    lv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_zero_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
